digit_classifier: RTL

Downstream consumer of the 14x14 binary image assembled by the image-reader stage. On a rising edge of the upstream `image_ready`, it latches the 196-bit `image_data` vector. It then streams per-pixel class weights from an external synchronous weight ROM and accumulates one signed score per class. A sequential argmax follows, and the block reports the winning digit with a one-cycle `digit_valid` pulse.

---
 rtl/digit_classifier_if.sv | 26 ++
 rtl/digit_classifier.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/digit_classifier_if.sv
// Bundle between the image-reader stage, the external weight ROM and the digit classifier.
// The master side supplies the image and ROM data; the slave side is the classifier.
interface digit_classifier_if #(
  parameter int NUM_CLASSES = 10,
  parameter int W_WIDTH     = 4,
  parameter int ACC_WIDTH   = 12
);
  logic [195:0]                   image_data;
  logic                           image_ready;
  logic [7:0]                     w_addr;
  logic [NUM_CLASSES*W_WIDTH-1:0] w_data;
  logic                           busy;
  logic [3:0]                     digit;
  logic [ACC_WIDTH-1:0]           best_score;
  logic                           digit_valid;

  modport master (
    output image_data, image_ready, w_data,
    input  w_addr, busy, digit, best_score, digit_valid
  );

  modport slave (
    input  image_data, image_ready, w_data,
    output w_addr, busy, digit, best_score, digit_valid
  );
endinterface

// File: rtl/digit_classifier.sv
// Linear 14x14 binary-image digit classifier: per-class weighted pixel sums streamed
// from a 1-cycle-latency weight ROM, followed by a sequential lowest-index argmax.
module digit_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int W_WIDTH     = 4,
  parameter int ACC_WIDTH   = 12
) (
  input logic               clk,
  input logic               reset_n,
  digit_classifier_if.slave bus
);

  localparam logic [7:0] LAST_C    = 8'd196;
  localparam logic [7:0] LAST_ADDR = 8'd195;
  localparam logic [3:0] LAST_IDX  = 4'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                        state_r, state_s;
  logic                          rdy_r;
  logic                          trig_s;
  logic [195:0]                  img_r;
  logic [7:0]                    cnt_r;
  logic [3:0]                    idx_r;
  logic [3:0]                    best_idx_r;
  logic signed [ACC_WIDTH-1:0]   best_r;
  logic signed [ACC_WIDTH-1:0]   acc_r  [NUM_CLASSES];
  logic signed [ACC_WIDTH-1:0]   wext_s [NUM_CLASSES];
  logic [7:0]                    pix_idx_s;
  logic                          pix_on_s;
  logic signed [ACC_WIDTH-1:0]   cand_s;
  logic signed [ACC_WIDTH-1:0]   nbest_s;
  logic [3:0]                    nidx_s;

  function automatic logic signed [ACC_WIDTH-1:0] sext_w(input logic [W_WIDTH-1:0] w);
    return {{(ACC_WIDTH-W_WIDTH){w[W_WIDTH-1]}}, w};
  endfunction

  assign trig_s = bus.image_ready & ~rdy_r;

  // Next-state logic for the capture / accumulate / argmax / report sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (trig_s) state_s = ST_ACCUM;  else state_s = ST_IDLE;
      ST_ACCUM:  if (cnt_r == LAST_C) state_s = ST_ARGMAX; else state_s = ST_ACCUM;
      ST_ARGMAX: if (idx_r == LAST_IDX) state_s = ST_DONE; else state_s = ST_ARGMAX;
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Datapath helpers: weight sign extension, current pixel and argmax candidate.
  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      wext_s[k] = sext_w(bus.w_data[k*W_WIDTH +: W_WIDTH]);
    end
    // ROM data in cycle c belongs to pixel c-1, stored at img bit 196-c.
    if (cnt_r == 8'd0) begin
      pix_idx_s = 8'd0;
      pix_on_s  = 1'b0;
    end else begin
      pix_idx_s = 8'd196 - cnt_r;
      pix_on_s  = img_r[pix_idx_s];
    end
    cand_s  = acc_r[idx_r];
    nbest_s = best_r;
    nidx_s  = best_idx_r;
    if (idx_r == 4'd0) begin
      nbest_s = cand_s;
      nidx_s  = 4'd0;
    end else if (cand_s > best_r) begin
      nbest_s = cand_s;
      nidx_s  = idx_r;
    end else begin
      nbest_s = best_r;
      nidx_s  = best_idx_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Capture, accumulation, argmax and registered result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_r           <= 1'b0;
      img_r           <= 196'd0;
      cnt_r           <= 8'd0;
      idx_r           <= 4'd0;
      best_idx_r      <= 4'd0;
      best_r          <= '0;
      bus.w_addr      <= 8'd0;
      bus.busy        <= 1'b0;
      bus.digit       <= 4'd0;
      bus.best_score  <= '0;
      bus.digit_valid <= 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) acc_r[k] <= '0;
    end else begin
      rdy_r <= bus.image_ready;
      case (state_r)
        ST_IDLE: begin
          if (trig_s) begin
            img_r      <= bus.image_data;
            cnt_r      <= 8'd0;
            idx_r      <= 4'd0;
            bus.w_addr <= 8'd0;
            bus.busy   <= 1'b1;
            for (int k = 0; k < NUM_CLASSES; k++) acc_r[k] <= '0;
          end
        end
        ST_ACCUM: begin
          cnt_r      <= cnt_r + 8'd1;
          bus.w_addr <= (cnt_r >= LAST_ADDR) ? LAST_ADDR : cnt_r + 8'd1;
          if (pix_on_s) begin
            for (int k = 0; k < NUM_CLASSES; k++) acc_r[k] <= acc_r[k] + wext_s[k];
          end
        end
        ST_ARGMAX: begin
          best_r     <= nbest_s;
          best_idx_r <= nidx_s;
          if (idx_r == LAST_IDX) begin
            idx_r           <= 4'd0;
            bus.digit       <= nidx_s;
            bus.best_score  <= nbest_s;
            bus.digit_valid <= 1'b1;
            bus.busy        <= 1'b0;
          end else begin
            idx_r <= idx_r + 4'd1;
          end
        end
        ST_DONE: begin
          bus.digit_valid <= 1'b0;
        end
        default: begin
          bus.digit_valid <= 1'b0;
          bus.busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
